// File: rtl/arith_program_runner.sv
// Small instruction engine: runs a loaded arithmetic program, streams results to an
// out channel and checks them against a loaded expected-value list.
module arith_program_runner #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NLocal             = 16,
    parameter int unsigned NProgram           = 16,
    parameter int unsigned NOut               = 16,
    parameter int unsigned MaxSteps           = 1000,
    localparam int unsigned W                 = MemoryElementWidth,
    localparam int unsigned LAW               = $clog2(NLocal),
    localparam int unsigned PAW               = $clog2(NProgram),
    localparam int unsigned OAW               = $clog2(NOut),
    localparam int unsigned InstrWidth        = 3 + LAW + 2 * (1 + W)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  loadProgram,
    input  logic [PAW-1:0]        loadAddress,
    input  logic [InstrWidth-1:0] loadData,
    input  logic                  loadExpect,
    input  logic [OAW-1:0]        expectAddress,
    input  logic [W-1:0]          expectData,
    input  logic [OAW:0]          expectCount,
    output logic                  busy,
    output logic                  finished,
    output logic                  success,
    output logic [1:0]            errorCode,
    output logic [31:0]           steps,
    output logic [OAW:0]          outCount,
    output logic [OAW:0]          failIndex,
    input  logic [OAW-1:0]        outReadAddress,
    output logic [W-1:0]          outReadData
);

    localparam int unsigned OCW = OAW + 1;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_OUT  = 3'd4;
    localparam logic [2:0] OP_JNZ  = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_STEPS    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CHECK, S_DONE} state_t;

    state_t state, state_next;

    logic [InstrWidth-1:0] prog_mem  [NProgram];
    logic [W-1:0]          exp_mem   [NOut];
    logic [W-1:0]          out_mem   [NOut];
    logic [W-1:0]          local_mem [NLocal];

    logic [PAW-1:0] ip;
    logic [OCW-1:0] out_pos;
    logic [OCW-1:0] exp_count;
    logic [OCW-1:0] chk_idx;

    logic [InstrWidth-1:0] instr;
    logic [2:0]            opcode;
    logic [LAW-1:0]        target;
    logic                  mode_a, mode_b;
    logic [W-1:0]          val_a, val_b;
    logic [W-1:0]          opnd_a, opnd_b;

    logic           load_ok;
    logic           step_limit, illegal, overflow, exec_err;
    logic [1:0]     err_next;
    logic           local_we, out_we;
    logic [W-1:0]   local_wdata;
    logic [PAW-1:0] ip_next;
    logic [OCW-1:0] chk_lim;
    logic           chk_end, chk_mismatch, counts_equal;

    // Instruction fetch and field split, MSB first: opcode, target, A, B.
    assign instr  = prog_mem[ip];
    assign opcode = instr[InstrWidth-1 -: 3];
    assign target = instr[InstrWidth-4 -: LAW];
    assign mode_a = instr[2*W+1];
    assign val_a  = instr[2*W -: W];
    assign mode_b = instr[W];
    assign val_b  = instr[W-1:0];
    assign opnd_a = mode_a ? local_mem[val_a[LAW-1:0]] : val_a;
    assign opnd_b = mode_b ? local_mem[val_b[LAW-1:0]] : val_b;

    assign load_ok     = (state == S_IDLE) || (state == S_DONE);
    assign outReadData = out_mem[outReadAddress];
    assign outCount    = out_pos;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) state_next = S_EXEC;
            S_EXEC: begin
                if (exec_err)              state_next = S_DONE;
                else if (opcode == OP_HALT) state_next = S_CHECK;
            end
            S_CHECK: if (chk_end || chk_mismatch) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Decode / control: error priority is step limit, then illegal opcode, then overflow.
    always_comb begin
        step_limit   = (steps == 32'(MaxSteps));
        illegal      = (opcode > OP_JNZ);
        overflow     = (opcode == OP_OUT) && (out_pos == OCW'(NOut));
        exec_err     = step_limit || illegal || overflow;
        err_next     = ERR_NONE;
        if (step_limit)   err_next = ERR_STEPS;
        else if (illegal) err_next = ERR_ILLEGAL;
        else if (overflow) err_next = ERR_OVERFLOW;
        local_we     = 1'b0;
        local_wdata  = opnd_a;
        out_we       = 1'b0;
        ip_next      = ip + PAW'(1);
        if (state == S_EXEC && !exec_err) begin
            unique case (opcode)
                OP_MOV: local_we = 1'b1;
                OP_ADD: begin local_we = 1'b1; local_wdata = opnd_a + opnd_b; end
                OP_SUB: begin local_we = 1'b1; local_wdata = opnd_a - opnd_b; end
                OP_OUT: out_we = 1'b1;
                OP_JNZ: if (opnd_a != '0) ip_next = opnd_b[PAW-1:0];
                default: ;
            endcase
        end
        counts_equal = (out_pos == exp_count);
        chk_lim      = (out_pos < exp_count) ? out_pos : exp_count;
        chk_end      = (chk_idx == chk_lim);
        chk_mismatch = !chk_end && (out_mem[chk_idx[OAW-1:0]] != exp_mem[chk_idx[OAW-1:0]]);
    end

    // Memories that reset leaves untouched.
    always_ff @(posedge clock) begin
        if (loadProgram && load_ok) prog_mem[loadAddress] <= loadData;
        if (loadExpect && load_ok)  exp_mem[expectAddress] <= expectData;
        if (out_we)                 out_mem[out_pos[OAW-1:0]] <= opnd_a;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ip        <= '0;
            steps     <= '0;
            out_pos   <= '0;
            exp_count <= '0;
            chk_idx   <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            success   <= 1'b0;
            errorCode <= ERR_NONE;
            failIndex <= '0;
            for (int i = 0; i < NLocal; i++) local_mem[i] <= '0;
        end else begin
            busy     <= (state_next == S_EXEC) || (state_next == S_CHECK);
            finished <= (state_next == S_DONE);
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ip        <= '0;
                        steps     <= '0;
                        out_pos   <= '0;
                        chk_idx   <= '0;
                        exp_count <= expectCount;
                        success   <= 1'b0;
                        errorCode <= ERR_NONE;
                        failIndex <= '0;
                        for (int i = 0; i < NLocal; i++) local_mem[i] <= '0;
                    end
                end
                S_EXEC: begin
                    if (exec_err) begin
                        errorCode <= err_next;
                        failIndex <= out_pos;
                        success   <= 1'b0;
                    end else begin
                        steps <= steps + 32'd1;
                        ip    <= ip_next;
                        if (local_we) local_mem[target] <= local_wdata;
                        if (out_we)   out_pos <= out_pos + OCW'(1);
                        if (opcode == OP_HALT) chk_idx <= '0;
                    end
                end
                S_CHECK: begin
                    if (chk_end) begin
                        success   <= counts_equal;
                        failIndex <= counts_equal ? '0 : out_pos;
                    end else if (chk_mismatch) begin
                        success   <= 1'b0;
                        failIndex <= chk_idx;
                    end else begin
                        chk_idx <= chk_idx + OCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_program_runner.sv
// Bench for arith_program_runner: table of programs with expected run results,
// expected records queued at start and compared when the run finishes.
module tb_arith_program_runner;

    localparam int unsigned W   = 12;
    localparam int unsigned OAW = 4;
    localparam int unsigned IW  = 33;
    localparam int unsigned NV  = 11;

    typedef struct packed {
        logic [15:0][IW-1:0] prog;
        logic [15:0][W-1:0]  expv;
        logic [OAW:0]        cnt;
        logic                succ;
        logic [1:0]          err;
        logic [31:0]         steps;
        logic [OAW:0]        oc;
        logic [OAW:0]        fi;
        logic                chk_steps;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset, start, loadProgram, loadExpect;
    logic [3:0]    loadAddress;
    logic [IW-1:0] loadData;
    logic [OAW-1:0] expectAddress, outReadAddress;
    logic [W-1:0]  expectData, outReadData;
    logic [OAW:0]  expectCount, outCount, failIndex;
    logic          busy, finished, success;
    logic [1:0]    errorCode;
    logic [31:0]   steps;

    vec_t vecs [NV];
    vec_t sb_q [$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    arith_program_runner dut (
        .clock(clock), .reset(reset), .start(start),
        .loadProgram(loadProgram), .loadAddress(loadAddress), .loadData(loadData),
        .loadExpect(loadExpect), .expectAddress(expectAddress), .expectData(expectData),
        .expectCount(expectCount), .busy(busy), .finished(finished), .success(success),
        .errorCode(errorCode), .steps(steps), .outCount(outCount), .failIndex(failIndex),
        .outReadAddress(outReadAddress), .outReadData(outReadData)
    );

    function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [3:0] t,
                                          input logic ma, input logic [11:0] va,
                                          input logic mb, input logic [11:0] vb);
        return {op, t, ma, va, mb, vb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic set_res(input int k, input logic [4:0] cnt, input logic succ,
                           input logic [1:0] err, input int st, input int oc,
                           input int fi, input logic cs);
        vecs[k].cnt       = cnt;
        vecs[k].succ      = succ;
        vecs[k].err       = err;
        vecs[k].steps     = 32'(st);
        vecs[k].oc        = 5'(oc);
        vecs[k].fi        = 5'(fi);
        vecs[k].chk_steps = cs;
    endtask

    task automatic load_vec(input int k);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            loadProgram   = 1'b1;
            loadAddress   = 4'(i);
            loadData      = vecs[k].prog[i];
            loadExpect    = 1'b1;
            expectAddress = 4'(i);
            expectData    = vecs[k].expv[i];
        end
        @(negedge clock);
        loadProgram = 1'b0;
        loadExpect  = 1'b0;
    endtask

    task automatic run_vec(input int k, input int pulse_at);
        vec_t e;
        int   cyc;
        load_vec(k);
        expectCount = vecs[k].cnt;
        start = 1'b1;
        sb_q.push_back(vecs[k]);
        @(negedge clock);
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", k), 32'(busy), 32'd1);
        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check($sformatf("v%0d finished", k), 32'(finished), 32'd1);
        if (finished) begin
            check($sformatf("v%0d success", k), 32'(success), 32'(e.succ));
            check($sformatf("v%0d errorCode", k), 32'(errorCode), 32'(e.err));
            check($sformatf("v%0d outCount", k), 32'(outCount), 32'(e.oc));
            check($sformatf("v%0d failIndex", k), 32'(failIndex), 32'(e.fi));
            check($sformatf("v%0d busy_done", k), 32'(busy), 32'd0);
            if (e.chk_steps) check($sformatf("v%0d steps", k), steps, e.steps);
            repeat (3) @(negedge clock);
            check($sformatf("v%0d hold_finished", k), 32'(finished), 32'd1);
            check($sformatf("v%0d hold_success", k), 32'(success), 32'(e.succ));
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] a, input logic [11:0] req);
        outReadAddress = a;
        #1;
        check(name, 32'(outReadData), 32'(req));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; loadProgram = 1'b0; loadExpect = 1'b0;
        loadAddress = '0; loadData = '0; expectAddress = '0; expectData = '0;
        expectCount = '0; outReadAddress = '0;

        for (int k = 0; k < NV; k++) vecs[k] = '0;
        // 0: 4-2 streamed once
        vecs[0].prog[0] = ins(3'd1, 4'd0, 1'b0, 12'd4, 1'b0, 12'd0);
        vecs[0].prog[1] = ins(3'd3, 4'd0, 1'b1, 12'd0, 1'b0, 12'd2);
        vecs[0].prog[2] = ins(3'd4, 4'd0, 1'b1, 12'd0, 1'b0, 12'd0);
        vecs[0].expv[0] = 12'd2;
        set_res(0, 5'd1, 1'b1, 2'd0, 4, 1, 0, 1'b1);
        // 1,2: 2-4 wraps to 4094
        vecs[1].prog[0] = ins(3'd3, 4'd1, 1'b0, 12'd2, 1'b0, 12'd4);
        vecs[1].prog[1] = ins(3'd4, 4'd0, 1'b1, 12'd1, 1'b0, 12'd0);
        vecs[1].expv[0] = 12'd4094;
        set_res(1, 5'd1, 1'b1, 2'd0, 3, 1, 0, 1'b1);
        vecs[2].prog = vecs[1].prog;
        vecs[2].expv[0] = 12'd5;
        set_res(2, 5'd1, 1'b0, 2'd0, 3, 1, 0, 1'b1);
        // 3: countdown loop 3,2,1
        vecs[3].prog[0] = ins(3'd1, 4'd0, 1'b0, 12'd3, 1'b0, 12'd0);
        vecs[3].prog[1] = ins(3'd4, 4'd0, 1'b1, 12'd0, 1'b0, 12'd0);
        vecs[3].prog[2] = ins(3'd3, 4'd0, 1'b1, 12'd0, 1'b0, 12'd1);
        vecs[3].prog[3] = ins(3'd5, 4'd0, 1'b1, 12'd0, 1'b0, 12'd1);
        vecs[3].expv[0] = 12'd3; vecs[3].expv[1] = 12'd2; vecs[3].expv[2] = 12'd1;
        set_res(3, 5'd3, 1'b1, 2'd0, 11, 3, 0, 1'b1);
        // 4: jump to self forever -> step limit
        vecs[4].prog[0] = ins(3'd5, 4'd0, 1'b0, 12'd1, 1'b0, 12'd0);
        set_res(4, 5'd0, 1'b0, 2'd3, 1000, 0, 0, 1'b1);
        // 5: illegal opcode at ip 0
        vecs[5].prog[0] = ins(3'd7, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0);
        set_res(5, 5'd0, 1'b0, 2'd1, 0, 0, 0, 1'b1);
        // 6: unbounded OUT loop -> out overflow after 16 words
        vecs[6].prog[0] = ins(3'd4, 4'd0, 1'b0, 12'd7, 1'b0, 12'd0);
        vecs[6].prog[1] = ins(3'd5, 4'd0, 1'b0, 12'd1, 1'b0, 12'd0);
        set_res(6, 5'd16, 1'b0, 2'd2, 32, 16, 16, 1'b0);
        // 7: more outputs than expected, common part matches
        vecs[7].prog[0] = ins(3'd4, 4'd0, 1'b0, 12'd5, 1'b0, 12'd0);
        vecs[7].prog[1] = ins(3'd4, 4'd0, 1'b0, 12'd6, 1'b0, 12'd0);
        vecs[7].expv[0] = 12'd5;
        set_res(7, 5'd1, 1'b0, 2'd0, 3, 2, 2, 1'b1);
        // 8: zero count passes
        set_res(8, 5'd0, 1'b1, 2'd0, 1, 0, 0, 1'b1);
        // 9: mismatch at index 2
        vecs[9].prog[0] = ins(3'd4, 4'd0, 1'b0, 12'd1, 1'b0, 12'd0);
        vecs[9].prog[1] = ins(3'd4, 4'd0, 1'b0, 12'd2, 1'b0, 12'd0);
        vecs[9].prog[2] = ins(3'd4, 4'd0, 1'b0, 12'd3, 1'b0, 12'd0);
        vecs[9].expv[0] = 12'd1; vecs[9].expv[1] = 12'd2; vecs[9].expv[2] = 12'd4;
        set_res(9, 5'd3, 1'b0, 2'd0, 4, 3, 2, 1'b1);
        // 10: fewer outputs than expected, common part matches
        vecs[10].prog[0] = ins(3'd4, 4'd0, 1'b0, 12'd5, 1'b0, 12'd0);
        vecs[10].expv[0] = 12'd5; vecs[10].expv[1] = 12'd9;
        set_res(10, 5'd2, 1'b0, 2'd0, 2, 1, 1, 1'b1);

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset finished", 32'(finished), 32'd0);
        check("reset success", 32'(success), 32'd0);
        check("reset errorCode", 32'(errorCode), 32'd0);
        check("reset steps", steps, 32'd0);
        check("reset outCount", 32'(outCount), 32'd0);
        check("reset failIndex", 32'(failIndex), 32'd0);

        for (int k = 0; k < NV; k++) begin
            run_vec(k, (k == 4) ? 500 : 0);
            if (k == 0) check_out("v0 outRead0", 4'd0, 12'd2);
            if (k == 1) check_out("v1 outRead0", 4'd0, 12'd4094);
            if (k == 3) check_out("v3 outRead2", 4'd2, 12'd1);
            if (k == 6) check_out("v6 outRead15", 4'd15, 12'd7);
        end

        // Reset in the middle of the countdown, then a clean rerun.
        load_vec(3);
        expectCount = 5'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset finished", 32'(finished), 32'd0);
        check("midreset steps", steps, 32'd0);
        check("midreset outCount", 32'(outCount), 32'd0);
        check("midreset errorCode", 32'(errorCode), 32'd0);
        run_vec(3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arith_program_runner.md
Name: arith_program_runner

Overview:
- Parametrised successor to the single-program fpga test harness: a small instruction engine that runs a loaded arithmetic program, streams results to an out channel and self-checks them against a loaded expected-value list.
- Reports finished/success exactly as the fixed harness does, but adds program loading, add/mov/jump instructions, step limiting and error reporting.
- Sits at the top of each FPGA test build; the board drives start and observes finished/success.

Parameters:
MemoryElementWidth, 12, width W of every data word
NLocal, 16, local memory words (power of 2); LAW = clog2(NLocal)
NProgram, 16, instruction slots (power of 2); PAW = clog2(NProgram)
NOut, 16, out channel / expected list depth (power of 2); OAW = clog2(NOut)
MaxSteps, 1000, executed-instruction limit per run
InstrWidth, 3+LAW+2*(1+W), derived; do not override

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run
loadProgram  in  1  write loadData to program[loadAddress]
loadAddress  in  PAW  program write address
loadData  in  InstrWidth  instruction word
loadExpect  in  1  write expectData to expected[expectAddress]
expectAddress  in  OAW  expected-list write address
expectData  in  W  expected value
expectCount  in  OAW+1  number of outputs the program must produce; sampled at start
busy  out  1  high in EXEC or CHECK
finished  out  1  high in DONE
success  out  1  valid when finished
errorCode  out  2  0 none, 1 illegal opcode, 2 out overflow, 3 step limit
steps  out  32  instructions executed this run
outCount  out  OAW+1  words written to out channel
failIndex  out  OAW+1  first mismatching index; equals outCount on a count mismatch; 0 on pass
outReadAddress  in  OAW  debug read of out channel
outReadData  out  W  combinational outMem[outReadAddress]

Behaviour:
- Instruction fields, MSB first: opcode[3], target[LAW], A = {modeA, valA[W]}, B = {modeB, valB[W]}. mode 0: operand is val (immediate). mode 1: operand is localMem[val[LAW-1:0]].
- Opcodes: 0 HALT; 1 MOV local[target]=A; 2 ADD local[target]=A+B; 3 SUBTRACT local[target]=A-B; 4 OUT outMem[outPos]=A, outPos+1; 5 JNZ if A!=0 then ip=B[PAW-1:0] else ip+1; 6,7 illegal.
- Arithmetic is modulo 2^W, with no flags. Example: 2-4 at W=12 gives 4094.
- States: IDLE, EXEC, CHECK, DONE.
- Reset: state IDLE, ip=0, steps=0, outPos=0, all localMem=0; outputs busy, finished, success, errorCode, failIndex, outCount are 0. Program and expected memories are not cleared by reset.
- Loads are accepted only in IDLE or DONE; they are ignored while busy. Load and start in the same cycle: the load is applied first, so the run sees the new word.
- start in IDLE or DONE: next cycle enters EXEC with ip=0, steps=0, outPos=0, localMem zeroed, finished/success/errorCode/failIndex cleared, expectCount latched. start while busy is ignored.
- EXEC: one instruction per cycle from program[ip]. steps increments for every executed instruction, HALT included. ip wraps modulo NProgram.
- HALT -> CHECK.
- Illegal opcode -> DONE, errorCode=1; the instruction is not counted.
- OUT with outPos==NOut -> DONE, errorCode=2; no write occurs.
- Step limit: if steps==MaxSteps when a further instruction would execute -> DONE, errorCode=3.
- On any error: success=0, failIndex=outCount.
- CHECK: compares index i=0.. one per cycle.
  - If outCount != latched expectCount: failIndex=min(outCount,expectCount)-clamped first difference, or outCount if all common entries match; result is fail.
  - First mismatch: failIndex=i, go to DONE with success=0.
  - All match and counts equal: success=1. A zero count passes in one cycle.
- DONE holds all outputs until start or reset.
- Reset mid-run returns to IDLE immediately in the next cycle; no partial completion is reported.

Test Plan:
- Program {MOV L0,4; SUBTRACT L0=L0-#2; OUT L0; HALT}, expected {2}, count 1 -> finished=1, success=1, steps=4, outCount=1, outReadData[0]=2.
- SUBTRACT L1=#2-#4; OUT L1; HALT, expected {4094} -> success=1, demonstrating wrap-around.
- Same program, expected {5} -> success=0, errorCode=0, failIndex=0.
- Countdown loop: MOV L0,3; OUT L0; SUB L0=L0-#1; JNZ L0,#1; HALT, expected {3,2,1} -> success=1, steps=11.
- JNZ #1 to self with MaxSteps=1000 -> errorCode=3, steps=1000, success=0; opcode 7 at ip 0 -> errorCode=1, steps=0.
- NOut+1 OUTs -> errorCode=2, outCount=NOut. Reset asserted mid-run, then restart -> clean pass; start pulsed while busy has no effect.
